// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, ALU codes, mux selects, states and output bundle (CTRL_STEP_EN adds STEP_WAIT)
package cpu_ctrl_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [2:0] ALU_INC  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [1:0] MUX_AB_R1 = 2'b00;
    localparam logic [1:0] MUX_AB_R6 = 2'b11;
    localparam logic       MUX3_PC   = 1'b0;
    localparam logic       MUX3_ALU  = 1'b1;
    localparam logic       MUX4_ALU  = 1'b0;
    localparam logic       MUX4_RDM  = 1'b1;
    localparam logic       MUX5_BUS  = 1'b0;
    localparam logic       MUX5_ALU  = 1'b1;

`ifdef CTRL_STEP_EN
    typedef enum logic [3:0] {
        S_FETCH_ADDR, S_MEM_RD, S_FETCH_LATCH, S_DECODE, S_PC_INC, S_EXEC,
        S_LS_ADDR, S_LD_RD, S_LD_WB, S_ST_DATA, S_ST_WR, S_HALT, S_STEP_WAIT
    } state_e;
`else
    typedef enum logic [3:0] {
        S_FETCH_ADDR, S_MEM_RD, S_FETCH_LATCH, S_DECODE, S_PC_INC, S_EXEC,
        S_LS_ADDR, S_LD_RD, S_LD_WB, S_ST_DATA, S_ST_WR, S_HALT
    } state_e;
`endif

    typedef struct packed {
        logic [5:0] wr_r;
        logic       wr_rdm;
        logic       wr_rem;
        logic [1:0] mux1;
        logic [1:0] mux2;
        logic       mux3;
        logic       mux4;
        logic       mux5;
        logic       rd;
        logic       oe;
        logic       cs;
        logic [2:0] codigo;
        logic       halted;
    } ctrl_out_t;

endpackage

// File: rtl/cpu_ctrl_dst_decode.sv
// rtl/cpu_ctrl_dst_decode.sv - destination field plus write strobe to one-hot R1..R6 enables
module cpu_ctrl_dst_decode (
    input  logic [2:0] dst_i,
    input  logic       wr_i,
    output logic [5:0] wr_r_o
);

    // dst 0 and 7 name no register, so they decode to no enable
    always_comb begin
        wr_r_o = 6'b000000;
        if (wr_i) begin
            case (dst_i)
                3'd1:    wr_r_o = 6'b000001;
                3'd2:    wr_r_o = 6'b000010;
                3'd3:    wr_r_o = 6'b000100;
                3'd4:    wr_r_o = 6'b001000;
                3'd5:    wr_r_o = 6'b010000;
                3'd6:    wr_r_o = 6'b100000;
                default: wr_r_o = 6'b000000;
            endcase
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle fetch/decode/execute controller (CTRL_STEP_EN enables single-step)
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] instr_op,
    input  logic [2:0] instr_dst,
    input  logic [1:0] instr_src,
    input  logic       step,
    output logic       escreve_R1,
    output logic       escreve_R2,
    output logic       escreve_R3,
    output logic       escreve_R4,
    output logic       escreve_R5,
    output logic       escreve_R6,
    output logic       escreve_RDM,
    output logic       escreve_REM,
    output logic [1:0] seleciona_mux1,
    output logic [1:0] seleciona_mux2,
    output logic       seleciona_mux3,
    output logic       seleciona_mux4,
    output logic       seleciona_mux5,
    output logic       RD,
    output logic       OE,
    output logic       CS,
    output logic [2:0] codigo,
    output logic       halted
);

    localparam int                WAIT_W    = $clog2(MEM_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT - 1);

`ifdef CTRL_STEP_EN
    localparam state_e S_DONE = S_STEP_WAIT;
`else
    localparam state_e S_DONE = S_FETCH_ADDR;
    logic unused_step;
    assign unused_step = step;
`endif

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [2:0]        op_q, op_d, dst_q, dst_d;
    logic [1:0]        src_q, src_d;
    logic              started_q;
    ctrl_out_t         out_q, out_d;
    logic              dst_wr_en;
    logic [5:0]        dst_wr_r;

    // next state; the first cycle after reset only loads FETCH_ADDR outputs
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_d   = src_q;
        if (!started_q) begin
            state_d = S_FETCH_ADDR;
        end else begin
            case (state_q)
                S_FETCH_ADDR: begin
                    state_d = S_MEM_RD;
                    wait_d  = WAIT_LAST;
                end
                S_MEM_RD: begin
                    if (wait_q == '0) state_d = S_FETCH_LATCH;
                    else              wait_d  = wait_q - WAIT_W'(1);
                end
                S_FETCH_LATCH: state_d = S_DECODE;
                S_DECODE: begin
                    op_d    = instr_op;
                    dst_d   = instr_dst;
                    src_d   = instr_src;
                    state_d = S_PC_INC;
                end
                S_PC_INC: begin
                    case (op_q)
                        OP_LOAD, OP_STORE: state_d = S_LS_ADDR;
                        OP_NOP:            state_d = S_DONE;
                        OP_HALT:           state_d = S_HALT;
                        default:           state_d = S_EXEC;
                    endcase
                end
                S_EXEC: state_d = S_DONE;
                S_LS_ADDR: begin
                    wait_d  = WAIT_LAST;
                    state_d = (op_q == OP_LOAD) ? S_LD_RD : S_ST_DATA;
                end
                S_LD_RD: begin
                    if (wait_q == '0) state_d = S_LD_WB;
                    else              wait_d  = wait_q - WAIT_W'(1);
                end
                S_LD_WB: state_d = S_DONE;
                S_ST_DATA: begin
                    wait_d  = WAIT_LAST;
                    state_d = S_ST_WR;
                end
                S_ST_WR: begin
                    if (wait_q == '0) state_d = S_DONE;
                    else              wait_d  = wait_q - WAIT_W'(1);
                end
                S_HALT: state_d = S_HALT;
`ifdef CTRL_STEP_EN
                S_STEP_WAIT: if (step) state_d = S_FETCH_ADDR;
`endif
                default: state_d = S_FETCH_ADDR;
            endcase
        end
    end

    assign dst_wr_en = (state_d == S_EXEC) || (state_d == S_LD_WB);

    cpu_ctrl_dst_decode u_dst_decode (
        .dst_i  (dst_d),
        .wr_i   (dst_wr_en),
        .wr_r_o (dst_wr_r)
    );

    // Moore outputs of the state being entered, so they can be registered with it
    always_comb begin
        out_d = '0;
        case (state_d)
            S_FETCH_ADDR: begin
                out_d.mux3   = MUX3_PC;
                out_d.wr_rem = 1'b1;
            end
            S_MEM_RD: begin
                out_d.cs = 1'b1;
                out_d.oe = 1'b1;
                out_d.rd = 1'b1;
            end
            S_FETCH_LATCH: begin
                out_d.cs     = 1'b1;
                out_d.oe     = 1'b1;
                out_d.rd     = 1'b1;
                out_d.mux5   = MUX5_BUS;
                out_d.wr_rdm = 1'b1;
            end
            S_PC_INC: begin
                out_d.mux1   = MUX_AB_R6;
                out_d.codigo = ALU_INC;
                out_d.mux4   = MUX4_ALU;
            end
            S_EXEC: begin
                out_d.mux1   = src_d;
                out_d.mux2   = src_d;
                out_d.codigo = op_d;
                out_d.mux4   = MUX4_ALU;
            end
            S_LS_ADDR: begin
                out_d.mux1   = src_d;
                out_d.codigo = ALU_PASS;
                out_d.mux3   = MUX3_ALU;
                out_d.wr_rem = 1'b1;
            end
            S_LD_RD: begin
                out_d.cs     = 1'b1;
                out_d.oe     = 1'b1;
                out_d.rd     = 1'b1;
                out_d.mux5   = MUX5_BUS;
                out_d.wr_rdm = (wait_d == '0);
            end
            S_LD_WB: out_d.mux4 = MUX4_RDM;
            S_ST_DATA: begin
                out_d.mux1   = MUX_AB_R1;
                out_d.codigo = ALU_PASS;
                out_d.mux5   = MUX5_ALU;
                out_d.wr_rdm = 1'b1;
            end
            S_ST_WR: out_d.cs = 1'b1;
            S_HALT:  out_d.halted = 1'b1;
            default: out_d = '0;
        endcase
        out_d.wr_r = (state_d == S_PC_INC) ? 6'b100000 : dst_wr_r;
    end

    // state, wait counter, latched instruction fields and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH_ADDR;
            wait_q    <= '0;
            op_q      <= '0;
            dst_q     <= '0;
            src_q     <= '0;
            started_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            started_q <= 1'b1;
            out_q     <= out_d;
        end
    end

    assign escreve_R1     = out_q.wr_r[0];
    assign escreve_R2     = out_q.wr_r[1];
    assign escreve_R3     = out_q.wr_r[2];
    assign escreve_R4     = out_q.wr_r[3];
    assign escreve_R5     = out_q.wr_r[4];
    assign escreve_R6     = out_q.wr_r[5];
    assign escreve_RDM    = out_q.wr_rdm;
    assign escreve_REM    = out_q.wr_rem;
    assign seleciona_mux1 = out_q.mux1;
    assign seleciona_mux2 = out_q.mux2;
    assign seleciona_mux3 = out_q.mux3;
    assign seleciona_mux4 = out_q.mux4;
    assign seleciona_mux5 = out_q.mux5;
    assign RD             = out_q.rd;
    assign OE             = out_q.oe;
    assign CS             = out_q.cs;
    assign codigo         = out_q.codigo;
    assign halted         = out_q.halted;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed cycle-by-cycle check of cpu_control_unit outputs
module tb_cpu_control_unit;

    localparam int MW = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] instr_op, instr_dst;
    logic [1:0] instr_src;
    logic       step;
    logic       escreve_R1, escreve_R2, escreve_R3, escreve_R4, escreve_R5, escreve_R6;
    logic       escreve_RDM, escreve_REM;
    logic [1:0] seleciona_mux1, seleciona_mux2;
    logic       seleciona_mux3, seleciona_mux4, seleciona_mux5;
    logic       RD, OE, CS;
    logic [2:0] codigo;
    logic       halted;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    cpu_control_unit #(.MEM_WAIT(MW)) dut (
        .clock          (clock),
        .reset          (reset),
        .instr_op       (instr_op),
        .instr_dst      (instr_dst),
        .instr_src      (instr_src),
        .step           (step),
        .escreve_R1     (escreve_R1),
        .escreve_R2     (escreve_R2),
        .escreve_R3     (escreve_R3),
        .escreve_R4     (escreve_R4),
        .escreve_R5     (escreve_R5),
        .escreve_R6     (escreve_R6),
        .escreve_RDM    (escreve_RDM),
        .escreve_REM    (escreve_REM),
        .seleciona_mux1 (seleciona_mux1),
        .seleciona_mux2 (seleciona_mux2),
        .seleciona_mux3 (seleciona_mux3),
        .seleciona_mux4 (seleciona_mux4),
        .seleciona_mux5 (seleciona_mux5),
        .RD             (RD),
        .OE             (OE),
        .CS             (CS),
        .codigo         (codigo),
        .halted         (halted)
    );

    // {R6..R1, RDM, REM, mux1, mux2, mux3, mux4, mux5, RD, OE, CS, codigo, halted}
    logic [21:0] obs;
    assign obs = {escreve_R6, escreve_R5, escreve_R4, escreve_R3, escreve_R2, escreve_R1,
                  escreve_RDM, escreve_REM, seleciona_mux1, seleciona_mux2,
                  seleciona_mux3, seleciona_mux4, seleciona_mux5, RD, OE, CS, codigo, halted};

    function automatic logic [21:0] ev(input logic [5:0] w, input logic rdm, input logic rem,
                                       input logic [1:0] m1, input logic [1:0] m2,
                                       input logic m3, input logic m4, input logic m5,
                                       input logic rd, input logic oe, input logic cs,
                                       input logic [2:0] cod, input logic h);
        return {w, rdm, rem, m1, m2, m3, m4, m5, rd, oe, cs, cod, h};
    endfunction

    task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    endtask

    // run one instruction from FETCH_ADDR, checking every cycle; wexp is the hand-picked dst enable
    task automatic run_instr(input string name, input logic [2:0] op, input logic [2:0] dst,
                             input logic [1:0] src, input logic [5:0] wexp);
        logic [21:0] exp_q[$];
        logic [21:0] rdcyc;
        rdcyc = ev(6'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 1, 3'd0, 0);
        instr_op  = op;
        instr_dst = dst;
        instr_src = src;
        exp_q.push_back(ev(6'd0, 0, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0));
        for (int k = 0; k < MW; k++) exp_q.push_back(rdcyc);
        exp_q.push_back(ev(6'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 1, 3'd0, 0));
        exp_q.push_back(22'd0);
        exp_q.push_back(ev(6'b100000, 0, 0, 2'b11, 2'd0, 0, 0, 0, 0, 0, 0, 3'b110, 0));
        case (op)
            3'b100: begin
                exp_q.push_back(ev(6'd0, 0, 1, src, 2'd0, 1, 0, 0, 0, 0, 0, 3'b111, 0));
                for (int k = 0; k < MW - 1; k++) exp_q.push_back(rdcyc);
                exp_q.push_back(ev(6'd0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 1, 3'd0, 0));
                exp_q.push_back(ev(wexp, 0, 0, 2'd0, 2'd0, 0, 1, 0, 0, 0, 0, 3'd0, 0));
            end
            3'b101: begin
                exp_q.push_back(ev(6'd0, 0, 1, src, 2'd0, 1, 0, 0, 0, 0, 0, 3'b111, 0));
                exp_q.push_back(ev(6'd0, 1, 0, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0, 3'b111, 0));
                for (int k = 0; k < MW; k++)
                    exp_q.push_back(ev(6'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 3'd0, 0));
            end
            3'b110: ;
            3'b111: exp_q.push_back(ev(6'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd0, 1));
            default: exp_q.push_back(ev(wexp, 0, 0, src, src, 0, 0, 0, 0, 0, 0, op, 0));
        endcase
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            if (i == 0) step = 1'b0;
            check($sformatf("%s_c%0d", name, i + 1), obs, exp_q[i]);
            if (i == 5) begin
                instr_op  = ~op;
                instr_dst = ~dst;
                instr_src = ~src;
            end
        end
`ifdef CTRL_STEP_EN
        if (op != 3'b111) begin
            repeat (3) begin
                @(negedge clock);
                check({name, "_stepwait"}, obs, 22'd0);
            end
            step = 1'b1;
        end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        step      = 1'b0;
        instr_op  = 3'd0;
        instr_dst = 3'd0;
        instr_src = 2'd0;
        repeat (3) @(negedge clock);
        check("reset_outs", obs, 22'd0);
        reset = 1'b0;

        run_instr("add_r3",  3'b000, 3'd3, 2'b01, 6'b000100);
        run_instr("sub_r1",  3'b001, 3'd1, 2'b10, 6'b000001);
        run_instr("and_d0",  3'b010, 3'd0, 2'b11, 6'b000000);
        run_instr("or_d7",   3'b011, 3'd7, 2'b00, 6'b000000);
        run_instr("nop",     3'b110, 3'd2, 2'b01, 6'b000000);
        run_instr("load_r2", 3'b100, 3'd2, 2'b01, 6'b000010);
        run_instr("store",   3'b101, 3'd5, 2'b10, 6'b000000);
        run_instr("load_r6", 3'b100, 3'd6, 2'b00, 6'b100000);

        instr_op  = 3'b000;
        instr_dst = 3'd4;
        instr_src = 2'b11;
        @(negedge clock);
        step = 1'b0;
        check("midrd_fetch", obs, ev(6'd0, 0, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0));
        @(negedge clock);
        check("midrd_memrd", obs, ev(6'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 1, 3'd0, 0));
        reset = 1'b1;
        @(negedge clock);
        check("midrd_reset_drop", obs, 22'd0);
        @(negedge clock);
        check("midrd_reset_hold", obs, 22'd0);
        reset = 1'b0;
        run_instr("add_r4", 3'b000, 3'd4, 2'b11, 6'b001000);

        run_instr("halt", 3'b111, 3'd1, 2'b00, 6'b000000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check($sformatf("halt_hold%0d", i),
                  obs, ev(6'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd0, 1));
        end
        reset = 1'b1;
        @(negedge clock);
        check("halt_reset", obs, 22'd0);
        reset = 1'b0;
        run_instr("or_r5", 3'b011, 3'd5, 2'b01, 6'b010000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle control FSM for the simple CPU. It sequences fetch, decode and execute by driving the register write enables (R1–R6, RDM, REM), the five datapath mux selects, the memory strobes (RD, OE, CS) and the 3-bit ALU code. It sits between the instruction fields decoded from RDM and the datapath pin interface, which it feeds directly. R6 is the program counter.

## Interface
Parameters:
- MEM_WAIT, default 2: cycles memory strobes are held per access (≥1).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- instr_op  in  3  opcode field of the instruction currently in RDM
- instr_dst  in  3  destination register, 1..6 = R1..R6
- instr_src  in  2  operand source code, driven to mux1/mux2
- step  in  1  single-step advance pulse (used only with CTRL_STEP_EN)
- escreve_R1..escreve_R6, escreve_RDM, escreve_REM  out  1 each  register write enables
- seleciona_mux1, seleciona_mux2  out  2 each  ALU A/B source (2'b11 = R6)
- seleciona_mux3  out  1  REM source: 0 = R6, 1 = ALU
- seleciona_mux4  out  1  register write data: 0 = ALU, 1 = RDM
- seleciona_mux5  out  1  RDM source: 0 = memory bus, 1 = ALU
- RD, OE, CS  out  1 each  memory read / output-enable / chip-select, active-high
- codigo  out  3  ALU operation
- halted  out  1  high in HALT

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LOAD, 101 STORE, 110 NOP, 111 HALT.
- ALU codes driven: 000–011 pass-through from the opcode; 110 = INC A; 111 = PASS A.
- Outputs are Moore, decoded from the state. Every output not listed for a state is 0.
- FETCH_ADDR: mux3=0, escreve_REM=1 → MEM_RD.
- MEM_RD: CS=OE=RD=1 for MEM_WAIT cycles (counter) → FETCH_LATCH.
- FETCH_LATCH: CS=OE=RD=1, mux5=0, escreve_RDM=1 → DECODE.
- DECODE: the controller registers instr_op, instr_dst and instr_src → PC_INC.
- PC_INC: mux1=11, codigo=110, mux4=0, escreve_R6=1. Next state by opcode:
  - ALU ops → EXEC
  - LOAD/STORE → LS_ADDR
  - NOP → FETCH_ADDR
  - HALT → HALT
- EXEC: mux1=mux2=src, codigo=op, mux4=0, escreve_R[dst]=1 → FETCH_ADDR.
- LS_ADDR: mux1=src, codigo=111, mux3=1, escreve_REM=1. Next: LOAD → LD_RD; STORE → ST_DATA.
- LD_RD: CS=OE=RD=1 for MEM_WAIT cycles, with escreve_RDM=1, mux5=0 in the last cycle → LD_WB.
- LD_WB: mux4=1, escreve_R[dst]=1 → FETCH_ADDR.
- ST_DATA: mux1=2'b00 (R1 data), codigo=111, mux5=1, escreve_RDM=1 → ST_WR.
- ST_WR: CS=1, RD=0, OE=0 for MEM_WAIT cycles → FETCH_ADDR.
- HALT: all enables 0, halted=1. Only reset exits.
- dst of 0 or 7 produces no register write; the instruction otherwise completes normally.
- At most one escreve_R* is high in any cycle.

## Timing
- Reset (synchronous) → FETCH_ADDR with all outputs 0, halted=0, and the wait counter and latched fields cleared.
- Reset asserted mid-access drops CS/OE/RD on the next edge. No partial write is retried.
- Instruction latency for MEM_WAIT=M:
  - ALU ops: M+5 cycles
  - NOP: M+4 cycles
  - LOAD: 2M+6 cycles
  - STORE: 2M+6 cycles
- The wait counter is log2(MEM_WAIT+1) bits wide and reloads on each memory-state entry.
- instr_* inputs are sampled only in DECODE. Changes at any other time are ignored.

## Configuration
- CTRL_STEP_EN defined:
  - After any instruction's final state, the FSM enters STEP_WAIT (all outputs 0) instead of FETCH_ADDR.
  - It moves to FETCH_ADDR on the cycle after step=1 is sampled.
  - step=1 outside STEP_WAIT is ignored.
- CTRL_STEP_EN undefined: STEP_WAIT does not exist, the step port is ignored, and execution runs continuously.

## Structure
- Shared package cpu_ctrl_pkg: opcode constants, ALU code constants (incl. INC/PASS), mux select constants, state enum.
- One sub-module, cpu_ctrl_dst_decode: combinational 3-bit dst + write strobe → six one-hot escreve_R* lines.

## Test plan
- Reset, MEM_WAIT=2: after reset release, FETCH_ADDR outputs escreve_REM=1, mux3=0. The next 2 cycles have CS=OE=RD=1, then escreve_RDM=1.
- ADD with dst=3, src=01: on cycle 7, escreve_R3=1, codigo=000, mux1=mux2=01. No other write enable is ever high simultaneously.
- LOAD with dst=2: a 10-cycle instruction. The LD_WB cycle has mux4=1, escreve_R2=1. Exactly one PC_INC pulse on escreve_R6.
- STORE: ST_WR holds CS=1, RD=0, OE=0 for 2 cycles. The preceding ST_DATA cycle has mux5=1.
- HALT: halted=1 and stays constant for 20 cycles. A reset pulse returns the FSM to FETCH_ADDR.
- With CTRL_STEP_EN: after a NOP, outputs are 0 until step pulses. Reset asserted during MEM_RD clears the strobes on the next edge.
